// File: rtl/prime_pkg.sv
// Shared state encoding and helpers for the prime sieve sequencer.
package prime_pkg;

   localparam int unsigned DEF_AW = 20;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StOuter,
      StMark,
      StScan,
      StEmit,
      StDone
   } sieve_state_t;

   // Double-width product so i*i can never wrap for any legal address width.
   function automatic logic sq_exceeds(input logic [31:0] i, input logic [31:0] n);
      logic [63:0] sq;
      sq = {32'd0, i} * {32'd0, i};
      return sq > {32'd0, n};
   endfunction

endpackage

// File: rtl/sieve_rd_wait.sv
// Read-latency tracker: an issue pulse yields a one-cycle rdata_ok_o exactly
// when the registered read address has produced valid RAM data.
module sieve_rd_wait #(
   parameter int unsigned RD_LAT = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic issue_i,
   output logic rdata_ok_o
);

   logic [2:0] cnt_q, cnt_d;
   logic       ok_q, ok_d;

   always_comb begin
      cnt_d = cnt_q;
      ok_d  = (cnt_q == 3'd1);
      if (issue_i) begin
         cnt_d = 3'(RD_LAT);
      end else if (cnt_q != 3'd0) begin
         cnt_d = cnt_q - 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 3'd0;
         ok_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ok_q  <= ok_d;
      end
   end

   assign rdata_ok_o = ok_q;

endmodule

// File: rtl/prime_sieve_ctrl.sv
// Sieve RAM sequencer: clear, Eratosthenes marking, scan and prime streaming.
// Build option SIEVE_SQUARE_START_EN starts each marking pass at i*i instead of 2*i.
module prime_sieve_ctrl
   import prime_pkg::*;
#(
   parameter int unsigned N_MAX  = 999999,
   parameter int unsigned AW     = prime_pkg::DEF_AW,
   parameter int unsigned RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   output logic          ram_wea,
   output logic [AW-1:0] ram_waddr,
   output logic          ram_wdata,
   output logic [AW-1:0] ram_raddr,
   input  logic          ram_rdata,
   output logic          prime_valid,
   input  logic          prime_ready,
   output logic [AW-1:0] prime_data,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] prime_count
);

   localparam logic [AW-1:0] NMaxA = AW'(N_MAX);
   localparam logic [AW:0]   NMaxW = (AW+1)'(N_MAX);

   sieve_state_t  state_q, state_d;
   logic [AW-1:0] a_q, a_d, i_q, i_d;
   logic [AW:0]   j_q, j_d, k_q, k_d;
   logic          pend_q, pend_d;
   logic          wea_q, wea_d, wdata_q, wdata_d, valid_q, valid_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic [AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d, data_q, data_d, count_q, count_d;
   logic          issue, rd_ok;

   sieve_rd_wait #(
      .RD_LAT(RD_LAT)
   ) u_rd_wait (
      .clk_i     (clk),
      .rst_ni    (rstn),
      .issue_i   (issue),
      .rdata_ok_o(rd_ok)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      pend_d  = pend_q;
      wea_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      raddr_d = raddr_q;
      valid_d = valid_q;
      data_d  = data_q;
      busy_d  = busy_q;
      done_d  = done_q;
      count_d = count_q;
      issue   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StClear;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               count_d = '0;
               a_d     = '0;
               i_d     = AW'(2);
            end
         end
         StClear: begin
            wea_d   = 1'b1;
            waddr_d = a_q;
            wdata_d = 1'b0;
            if (a_q == NMaxA) begin
               state_d = StOuter;
            end else begin
               a_d = a_q + AW'(1);
            end
         end
         StOuter: begin
            if (!pend_q) begin
               if (sq_exceeds(32'(i_q), 32'(N_MAX))) begin
                  state_d = StScan;
                  k_d     = (AW+1)'(2);
               end else begin
                  raddr_d = i_q;
                  issue   = 1'b1;
                  pend_d  = 1'b1;
               end
            end else if (rd_ok) begin
               pend_d = 1'b0;
               if (ram_rdata) begin
                  i_d = i_q + AW'(1);
               end else begin
`ifdef SIEVE_SQUARE_START_EN
                  j_d = {1'b0, i_q} * {1'b0, i_q};
`else
                  j_d = {i_q, 1'b0};
`endif
                  state_d = StMark;
               end
            end
         end
         StMark: begin
            if (j_q <= NMaxW) begin
               wea_d   = 1'b1;
               waddr_d = j_q[AW-1:0];
               wdata_d = 1'b1;
               j_d     = j_q + {1'b0, i_q};
            end else begin
               i_d     = i_q + AW'(1);
               state_d = StOuter;
            end
         end
         StScan: begin
            if (!pend_q) begin
               if (k_q > NMaxW) begin
                  state_d = StDone;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  raddr_d = k_q[AW-1:0];
                  issue   = 1'b1;
                  pend_d  = 1'b1;
               end
            end else if (rd_ok) begin
               pend_d = 1'b0;
               if (ram_rdata) begin
                  k_d = k_q + (AW+1)'(1);
               end else begin
                  data_d  = k_q[AW-1:0];
                  valid_d = 1'b1;
                  state_d = StEmit;
               end
            end
         end
         StEmit: begin
            if (prime_ready) begin
               valid_d = 1'b0;
               count_d = count_q + AW'(1);
               k_d     = k_q + (AW+1)'(1);
               state_d = StScan;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         a_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
         pend_q  <= 1'b0;
         wea_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= 1'b0;
         raddr_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         i_q     <= i_d;
         j_q     <= j_d;
         k_q     <= k_d;
         pend_q  <= pend_d;
         wea_q   <= wea_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         raddr_q <= raddr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   assign ram_wea     = wea_q;
   assign ram_waddr   = waddr_q;
   assign ram_wdata   = wdata_q;
   assign ram_raddr   = raddr_q;
   assign prime_valid = valid_q;
   assign prime_data  = data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign prime_count = count_q;

endmodule

// File: tb/tb_prime_sieve_ctrl.sv
// Self-checking bench: three sieve instances (N_MAX 30, 2, 100) with behavioural RAMs.
module tb_prime_sieve_ctrl;

   localparam int unsigned AW = 20;
   localparam int NI = 3;

   typedef struct {
      int count;
      int wea;
   } vec_t;

   logic clk = 1'b0;
   logic [NI-1:0] rstn, start, ready, wea, wdata, rdata, valid, busy, done;
   logic [NI-1:0][AW-1:0] waddr, raddr, pdata, pcount;
   logic [NI-1:0] start_req;

   int n_cmp = 0;
   int n_bad = 0;
   int got [NI][64];
   int got_n [NI];
   int wea_n [NI];
   vec_t tab [NI];
   int pr [25];
   bit stall_en, stalled, inj_en, inj_mark, inj_emit;
   int stall_left, stall_cnt0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int unsigned NM = (g == 0) ? 30 : (g == 1) ? 2 : 100;
      logic mem [0:127];
      logic [1:0] pipe;

      prime_sieve_ctrl #(
         .N_MAX (NM),
         .AW    (AW),
         .RD_LAT(2)
      ) u_dut (
         .clk        (clk),
         .rstn       (rstn[g]),
         .start      (start[g]),
         .ram_wea    (wea[g]),
         .ram_waddr  (waddr[g]),
         .ram_wdata  (wdata[g]),
         .ram_raddr  (raddr[g]),
         .ram_rdata  (rdata[g]),
         .prime_valid(valid[g]),
         .prime_ready(ready[g]),
         .prime_data (pdata[g]),
         .busy       (busy[g]),
         .done       (done[g]),
         .prime_count(pcount[g])
      );

      // Two register stages give the RD_LAT=2 read behaviour.
      always @(posedge clk) begin
         if (wea[g]) mem[waddr[g][6:0]] <= wdata[g];
         pipe <= {pipe[0], mem[raddr[g][6:0]]};
      end
      assign rdata[g] = pipe[1];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      start = start_req;
      start_req = '0;
      ready = '1;
      if (stall_en) begin
         if (stall_left == 0 && !stalled && valid[0] && pdata[0] == 5) begin
            stalled = 1'b1;
            stall_left = 5;
            stall_cnt0 = int'(pcount[0]);
         end
         if (stall_left > 0) begin
            ready[0] = 1'b0;
            stall_left--;
            chk("stall_valid", valid[0], 1);
            chk("stall_data", pdata[0], 5);
            chk("stall_count", pcount[0], stall_cnt0);
         end
      end
      if (inj_en) begin
         if (!inj_mark && wea[2] && wdata[2]) begin
            start[2] = 1'b1;
            inj_mark = 1'b1;
         end else if (!inj_emit && valid[2] && pdata[2] == 11) begin
            start[2] = 1'b1;
            inj_emit = 1'b1;
         end
      end
      for (int g = 0; g < NI; g++) begin
         if (valid[g] && ready[g] && got_n[g] < 64) begin
            got[g][got_n[g]] = int'(pdata[g]);
            got_n[g]++;
         end
         if (wea[g]) wea_n[g]++;
      end
   endtask

   task automatic start_run(input logic [NI-1:0] mask);
      for (int g = 0; g < NI; g++) begin
         if (mask[g]) begin
            got_n[g] = 0;
            wea_n[g] = 0;
            for (int i = 0; i < 64; i++) got[g][i] = -1;
         end
      end
      start_req = mask;
      cycle();
      cycle();
      for (int g = 0; g < NI; g++) begin
         if (mask[g]) begin
            chk($sformatf("g%0d_busy_after_start", g), busy[g], 1);
            chk($sformatf("g%0d_done_after_start", g), done[g], 0);
            chk($sformatf("g%0d_count_after_start", g), pcount[g], 0);
         end
      end
   endtask

   task automatic run_until_done(input logic [NI-1:0] mask, input string tag);
      int cyc;
      cyc = 0;
      while (((done & mask) != mask) && cyc < 4000) begin
         cycle();
         cyc++;
      end
      chk({tag, "_finished"}, ((done & mask) == mask) ? 1 : 0, 1);
   endtask

   task automatic check_run(input int g, input string tag);
      chk($sformatf("%s_g%0d_nprimes", tag, g), got_n[g], tab[g].count);
      chk($sformatf("%s_g%0d_prime_count", tag, g), pcount[g], tab[g].count);
      chk($sformatf("%s_g%0d_done", tag, g), done[g], 1);
      chk($sformatf("%s_g%0d_busy", tag, g), busy[g], 0);
      chk($sformatf("%s_g%0d_wea_cycles", tag, g), wea_n[g], tab[g].wea);
      for (int i = 0; i < tab[g].count; i++) begin
         chk($sformatf("%s_g%0d_prime%0d", tag, g, i), got[g][i], pr[i]);
      end
   endtask

   task automatic chk_zero(input int g, input string tag);
      chk($sformatf("%s_g%0d_ctl", tag, g),
          {wea[g], wdata[g], valid[g], busy[g], done[g]}, 0);
      chk($sformatf("%s_g%0d_bus", tag, g),
          waddr[g] | raddr[g] | pdata[g] | pcount[g], 0);
   endtask

   initial begin
      int cyc;
      pr = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47,
             53, 59, 61, 67, 71, 73, 79, 83, 89, 97};
`ifdef SIEVE_SQUARE_START_EN
      tab[0] = '{10, 55};
      tab[1] = '{1, 3};
      tab[2] = '{25, 205};
`else
      tab[0] = '{10, 59};
      tab[1] = '{1, 3};
      tab[2] = '{25, 214};
`endif
      rstn = '0;
      start = '0;
      ready = '1;
      start_req = '0;
      stall_en = 1'b0;
      stalled = 1'b0;
      stall_left = 0;
      stall_cnt0 = 0;
      inj_en = 1'b0;
      inj_mark = 1'b0;
      inj_emit = 1'b0;
      for (int g = 0; g < NI; g++) begin
         got_n[g] = 0;
         wea_n[g] = 0;
      end

      repeat (3) @(negedge clk);
      for (int g = 0; g < NI; g++) chk_zero(g, "reset");
      rstn = '1;
      cycle();

      // All three instances; back-pressure on g0, ignored starts on g2.
      stall_en = 1'b1;
      inj_en = 1'b1;
      start_run(3'b111);
      run_until_done(3'b111, "run1");
      for (int g = 0; g < NI; g++) check_run(g, "run1");
      chk("stall_seen", stalled, 1);
      chk("inject_mark_seen", inj_mark, 1);
      chk("inject_emit_seen", inj_emit, 1);
      stall_en = 1'b0;
      inj_en = 1'b0;

      // Start from DONE gives an identical second run.
      start_run(3'b001);
      run_until_done(3'b001, "run2");
      check_run(0, "run2");

      // Reset while marking multiples of 3.
      start_run(3'b001);
      cyc = 0;
      while (!(wea[0] && wdata[0] && waddr[0] == 9) && cyc < 2000) begin
         cycle();
         cyc++;
      end
      chk("mark_i3_reached", (wea[0] && wdata[0] && waddr[0] == 9) ? 1 : 0, 1);
      rstn[0] = 1'b0;
      #1;
      chk_zero(0, "async_reset");
      repeat (3) cycle();
      chk_zero(0, "held_reset");
      rstn[0] = 1'b1;
      cycle();
      start_run(3'b001);
      run_until_done(3'b001, "run3");
      check_run(0, "run3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
